// File: rtl/zap_dmem_request.sv
// ---------------------------------------------------------------------------
// zap_dmem_request
//
// Data-side bus initiator that sits between the ALU stage flops and the
// memory stage. It takes one load/store request per instruction, formats the
// store data and byte selects, runs a single Wishbone-style transfer, and
// stalls the pipeline until the transfer finishes. The raw 32-bit read word
// and a fault flag are returned with a one-cycle completion pulse. Load
// alignment and sign extension are done further down the pipe.
//
// Parameters:
//   TIMEOUT   bus watchdog limit in cycles from strobe assertion (0 = off)
//
// Optional build macro:
//   ZAP_DMEM_ALIGN_CHECK_EN  when defined, a misaligned halfword/word request
//                            faults immediately (IDLE -> DONE, no bus cycle).
//                            When undefined, low address bits only steer the
//                            byte lanes and selects.
//
// Ports:
//   i_clk, i_reset              clock, asynchronous active-low reset
//   i_clear_from_writeback      pipeline flush
//   i_mem_load_ff/_store_ff     request (store wins if both high)
//   i_mem_address_ff            byte address
//   i_mem_srcdest_value_ff      right-justified store data
//   i_byte_ff, i_half_ff        access size (word if neither)
//   o_wb_*, i_wb_*              Wishbone single-transfer initiator port
//   o_data_stall                combinational pipeline hold
//   o_mem_done, o_mem_fault     one-cycle completion pulse and fault status
//   o_mem_rd_data               read word captured from the last load
//   o_dbg_state                 current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a request is a level on i_mem_load_ff/i_mem_store_ff held by the
// ALU-stage flops; it is consumed on the clock edge where o_data_stall first
// goes low (the DONE cycle). On the bus, o_wb_cyc/o_wb_stb stay high and all
// o_wb_* fields stay stable until a cycle with i_wb_ack or i_wb_err (or the
// watchdog expiring), after which cyc/stb drop on the next edge.
// ---------------------------------------------------------------------------
module zap_dmem_request #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_mem_load_ff,
  input  logic        i_mem_store_ff,
  input  logic [31:0] i_mem_address_ff,
  input  logic [31:0] i_mem_srcdest_value_ff,
  input  logic        i_byte_ff,
  input  logic        i_half_ff,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_data_stall,
  output logic        o_mem_done,
  output logic [31:0] o_mem_rd_data,
  output logic        o_mem_fault,
  output logic [1:0]  o_dbg_state
);

  // Counter width; a disabled watchdog still keeps a 1-bit (unused) counter
  // so the declarations stay legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO_VAL = (CW + 1)'(TIMEOUT);
  localparam logic [CW:0] CNT_ONE = (CW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           cyc_q, cyc_d;
  logic           stb_q, stb_d;
  logic           we_q, we_d;
  logic [31:0]    adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [3:0]     sel_q, sel_d;
  logic [31:0]    rd_data_q, rd_data_d;
  logic           fault_q, fault_d;
  logic           flush_q, flush_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           req;
  logic           is_store;
  logic           accept;
  logic           misaligned;
  logic [3:0]     fmt_sel;
  logic [31:0]    fmt_dat;
  logic [CW:0]    cnt_inc;
  logic           timeout_hit;

  assign req      = i_mem_load_ff | i_mem_store_ff;
  // A simultaneous load and store is treated as a store.
  assign is_store = i_mem_store_ff;
  assign accept   = req & ~i_clear_from_writeback;

`ifdef ZAP_DMEM_ALIGN_CHECK_EN
  // Bytes are always aligned; halfwords need addr[0]=0, words addr[1:0]=0.
  assign misaligned = ~i_byte_ff &
                      (i_half_ff ? i_mem_address_ff[0]
                                 : (i_mem_address_ff[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Store lane replication: the slave picks the lanes named by sel, so the
  // right-justified data is copied into every lane it could land in.
  always_comb begin
    fmt_sel = 4'b1111;
    fmt_dat = 32'd0;
    if (is_store) begin
      if (i_byte_ff) begin
        fmt_sel = 4'b0001 << i_mem_address_ff[1:0];
        fmt_dat = {4{i_mem_srcdest_value_ff[7:0]}};
      end else if (i_half_ff) begin
        fmt_sel = i_mem_address_ff[1] ? 4'b1100 : 4'b0011;
        fmt_dat = {2{i_mem_srcdest_value_ff[15:0]}};
      end else begin
        fmt_sel = 4'b1111;
        fmt_dat = i_mem_srcdest_value_ff;
      end
    end
  end

  // cnt_q counts completed strobe cycles without a response; the watchdog
  // fires in the cycle that would make it reach TIMEOUT.
  assign cnt_inc     = {1'b0, cnt_q} + CNT_ONE;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rd_data_d = rd_data_q;
    fault_d   = fault_q;
    flush_d   = flush_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = is_store;
          adr_d   = {i_mem_address_ff[31:2], 2'b00};
          sel_d   = fmt_sel;
          dat_d   = fmt_dat;
          cnt_d   = '0;
          flush_d = 1'b0;
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            fault_d = 1'b0;
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        // A flush never abandons the transfer; it only marks the result
        // for discard.
        if (i_clear_from_writeback) begin
          flush_d = 1'b1;
        end
        // Response is checked before the watchdog so a same-cycle ack wins.
        if (i_wb_ack | i_wb_err) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          fault_d = i_wb_err;
          if (!we_q) begin
            rd_data_d = i_wb_dat;
          end
          state_d = S_DONE;
        end else if (timeout_hit) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end

      S_DONE: begin
        flush_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      sel_q     <= 4'd0;
      rd_data_q <= 32'd0;
      fault_q   <= 1'b0;
      flush_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rd_data_q <= rd_data_d;
      fault_q   <= fault_d;
      flush_q   <= flush_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = stb_q;
  assign o_wb_we       = we_q;
  assign o_wb_adr      = adr_q;
  assign o_wb_dat      = dat_q;
  assign o_wb_sel      = sel_q;
  assign o_mem_rd_data = rd_data_q;
  assign o_dbg_state   = state_q;

  // Stall is gated by reset so every output reads 0 while reset is held,
  // even if the request inputs are still high. It is low in DONE so the
  // pipeline advances on that edge.
  assign o_data_stall = i_reset &
                        (((state_q == S_IDLE) & accept) | (state_q == S_BUSY));

  assign o_mem_done  = (state_q == S_DONE) & ~flush_q;
  assign o_mem_fault = (state_q == S_DONE) & ~flush_q & fault_q;

endmodule

// File: tb/tb_zap_dmem_request.sv
// ---------------------------------------------------------------------------
// Testbench for zap_dmem_request (TIMEOUT = 4).
// Inputs are driven 2 time units after a rising edge and outputs sampled
// 3 units after it; the bus responder updates ack/err 1 unit after the edge.
// ---------------------------------------------------------------------------
module tb_zap_dmem_request;

  localparam int TO = 4;

  logic        i_clk;
  logic        i_reset;
  logic        i_clear_from_writeback;
  logic        i_mem_load_ff;
  logic        i_mem_store_ff;
  logic [31:0] i_mem_address_ff;
  logic [31:0] i_mem_srcdest_value_ff;
  logic        i_byte_ff;
  logic        i_half_ff;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic        o_data_stall;
  logic        o_mem_done;
  logic [31:0] o_mem_rd_data;
  logic        o_mem_fault;
  logic [1:0]  o_dbg_state;

  zap_dmem_request #(.TIMEOUT(TO)) dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_mem_load_ff          (i_mem_load_ff),
    .i_mem_store_ff         (i_mem_store_ff),
    .i_mem_address_ff       (i_mem_address_ff),
    .i_mem_srcdest_value_ff (i_mem_srcdest_value_ff),
    .i_byte_ff              (i_byte_ff),
    .i_half_ff              (i_half_ff),
    .o_wb_cyc               (o_wb_cyc),
    .o_wb_stb               (o_wb_stb),
    .o_wb_we                (o_wb_we),
    .o_wb_adr               (o_wb_adr),
    .o_wb_dat               (o_wb_dat),
    .o_wb_sel               (o_wb_sel),
    .i_wb_dat               (i_wb_dat),
    .i_wb_ack               (i_wb_ack),
    .i_wb_err               (i_wb_err),
    .o_data_stall           (o_data_stall),
    .o_mem_done             (o_mem_done),
    .o_mem_rd_data          (o_mem_rd_data),
    .o_mem_fault            (o_mem_fault),
    .o_dbg_state            (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];   // {fault, rd_data}
  logic [31:0] model_rd;

  // bus responder controls: mode 0 = silent, 1 = ack, 2 = err
  int          bus_mode = 1;
  int          bus_wait = 0;
  int          stb_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  initial begin
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    i_wb_dat = 32'd0;
    forever begin
      @(posedge i_clk);
      #1;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      if (o_wb_stb) begin
        if (stb_cycles == bus_wait) begin
          if (bus_mode == 1) i_wb_ack = 1'b1;
          else if (bus_mode == 2) i_wb_err = 1'b1;
        end
        stb_cycles++;
      end else begin
        stb_cycles = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drop_req();
    i_mem_load_ff          = 1'b0;
    i_mem_store_ff         = 1'b0;
    i_byte_ff              = 1'b0;
    i_half_ff              = 1'b0;
    i_mem_address_ff       = 32'd0;
    i_mem_srcdest_value_ff = 32'd0;
    i_clear_from_writeback = 1'b0;
  endtask

  // Called at edge+2. Holds the request until the completion cycle,
  // checks bus fields on the first strobe cycle, stall/strobe counts,
  // completion latency, and pops the scoreboard on o_mem_done.
  task automatic run_req(input string tag, input logic ld, input logic st,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic bt, input logic hf,
                         input logic [31:0] exp_adr, input logic [3:0] exp_sel,
                         input logic [31:0] exp_dat, input logic exp_we,
                         input int exp_lat, input int exp_stb,
                         input logic exp_fault, input logic [31:0] exp_rd);
    int k = 0;
    int stall_cnt = 0;
    int stb_cnt = 0;
    bit got = 0;
    logic [32:0] exp_v;
    exp_q.push_back({exp_fault, exp_rd});
    i_mem_load_ff          = ld;
    i_mem_store_ff         = st;
    i_mem_address_ff       = addr;
    i_mem_srcdest_value_ff = data;
    i_byte_ff              = bt;
    i_half_ff              = hf;
    #1;
    while (!got && k <= 40) begin
      if (o_data_stall) stall_cnt++;
      if (o_wb_stb) begin
        stb_cnt++;
        if (stb_cnt == 1) begin
          check({tag, "_adr"}, o_wb_adr, exp_adr);
          check({tag, "_sel"}, {28'd0, o_wb_sel}, {28'd0, exp_sel});
          check({tag, "_dat"}, o_wb_dat, exp_dat);
          check({tag, "_we"}, {31'd0, o_wb_we}, {31'd0, exp_we});
          check({tag, "_cyc"}, {31'd0, o_wb_cyc}, 32'd1);
        end
      end
      if (o_mem_done) begin
        got = 1;
        check({tag, "_sb_pending"}, exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check({tag, "_fault"}, {31'd0, o_mem_fault}, {31'd0, exp_v[32]});
          check({tag, "_rd"}, o_mem_rd_data, exp_v[31:0]);
        end
      end else begin
        @(posedge i_clk);
        #3;
        k++;
      end
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_stall_cycles"}, stall_cnt, exp_lat);
    check({tag, "_stb_cycles"}, stb_cnt, exp_stb);
    @(posedge i_clk);
    #2;
    drop_req();
    #1;
    check({tag, "_done_one_cycle"}, {31'd0, o_mem_done}, 32'd0);
    check({tag, "_back_idle"}, {30'd0, o_dbg_state}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int stb_cnt;
    bit done_seen;
    drop_req();
    i_reset  = 1'b0;
    model_rd = 32'd0;

    // Reset state
    repeat (3) @(posedge i_clk);
    #3;
    check("rst_bus", {28'd0, o_wb_cyc, o_wb_stb, o_wb_we, 1'b0}, 32'd0);
    check("rst_adr", o_wb_adr, 32'd0);
    check("rst_dat", o_wb_dat, 32'd0);
    check("rst_sel", {28'd0, o_wb_sel}, 32'd0);
    check("rst_flags", {29'd0, o_data_stall, o_mem_done, o_mem_fault}, 32'd0);
    check("rst_rd", o_mem_rd_data, 32'd0);
    check("rst_state", {30'd0, o_dbg_state}, 32'd0);
    @(posedge i_clk);
    #2;
    i_reset = 1'b1;

    // Store byte, zero-wait ack
    bus_mode = 1; bus_wait = 0;
    run_req("st_byte", 1'b0, 1'b1, 32'h0000_0103, 32'h0000_00A5, 1'b1, 1'b0,
            32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 1'b1, 2, 1, 1'b0, model_rd);

    // Load word with 3 wait states; ack coincides with the watchdog limit
    bus_mode = 1; bus_wait = 3; i_wb_dat = 32'hDEAD_BEEF;
    run_req("ld_word", 1'b1, 1'b0, 32'h0000_0200, 32'h1111_2222, 1'b0, 1'b0,
            32'h0000_0200, 4'b1111, 32'h0000_0000, 1'b0, 5, 4, 1'b0, 32'hDEAD_BEEF);
    model_rd = 32'hDEAD_BEEF;

    // Store half, bus error
    bus_mode = 2; bus_wait = 0;
    run_req("st_half_err", 1'b0, 1'b1, 32'h0000_0002, 32'h0000_1234, 1'b0, 1'b1,
            32'h0000_0000, 4'b1100, 32'h1234_1234, 1'b1, 2, 1, 1'b1, model_rd);

    // Watchdog: silent slave, strobe for TO cycles then fault
    bus_mode = 0; bus_wait = 0; i_wb_dat = 32'h7777_7777;
    run_req("ld_timeout", 1'b1, 1'b0, 32'h0000_0300, 32'd0, 1'b0, 1'b0,
            32'h0000_0300, 4'b1111, 32'h0000_0000, 1'b0, TO + 1, TO, 1'b1, model_rd);

    // Next request after timeout, one wait state
    bus_mode = 1; bus_wait = 1;
    run_req("st_word", 1'b0, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 1'b0, 1'b0,
            32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 1'b1, 3, 2, 1'b0, model_rd);

    // Misaligned word load
    bus_mode = 1; bus_wait = 0; i_wb_dat = 32'h0BAD_F00D;
`ifdef ZAP_DMEM_ALIGN_CHECK_EN
    run_req("ld_misalign", 1'b1, 1'b0, 32'h0000_0006, 32'd0, 1'b0, 1'b0,
            32'h0000_0004, 4'b1111, 32'h0000_0000, 1'b0, 1, 0, 1'b1, model_rd);
`else
    run_req("ld_misalign", 1'b1, 1'b0, 32'h0000_0006, 32'd0, 1'b0, 1'b0,
            32'h0000_0004, 4'b1111, 32'h0000_0000, 1'b0, 2, 1, 1'b0, 32'h0BAD_F00D);
    model_rd = 32'h0BAD_F00D;
`endif

    // Load and store together behave as a store (byte lane 1)
    bus_mode = 1; bus_wait = 0;
    run_req("ld_st_both", 1'b1, 1'b1, 32'h0000_0021, 32'h0000_007F, 1'b1, 1'b0,
            32'h0000_0020, 4'b0010, 32'h7F7F_7F7F, 1'b1, 2, 1, 1'b0, model_rd);

    // Request with flush in IDLE is not accepted
    i_mem_load_ff = 1'b1;
    i_mem_address_ff = 32'h0000_0080;
    i_clear_from_writeback = 1'b1;
    #1;
    check("clr_idle_stall", {31'd0, o_data_stall}, 32'd0);
    stb_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #3;
      if (o_wb_cyc || o_wb_stb) stb_cnt++;
    end
    check("clr_idle_no_bus", stb_cnt, 32'd0);
    check("clr_idle_state", {30'd0, o_dbg_state}, 32'd0);
    @(posedge i_clk);
    #2;
    drop_req();

    // Flush during BUSY: transfer runs to ack, result discarded
    bus_mode = 1; bus_wait = 2; i_wb_dat = 32'h1111_1111;
    i_mem_load_ff = 1'b1;
    i_mem_address_ff = 32'h0000_0400;
    @(posedge i_clk);
    #2;
    drop_req();
    i_clear_from_writeback = 1'b1;
    #1;
    check("flush_stb_busy", {31'd0, o_wb_stb}, 32'd1);
    stb_cnt = 1;
    done_seen = 0;
    @(posedge i_clk);
    #2;
    i_clear_from_writeback = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (o_wb_stb) stb_cnt++;
      if (o_mem_done || o_mem_fault) done_seen = 1;
      @(posedge i_clk);
      #3;
    end
    check("flush_stb_cycles", stb_cnt, 32'd3);
    check("flush_no_done", {31'd0, done_seen}, 32'd0);
    check("flush_state", {30'd0, o_dbg_state}, 32'd0);
    check("flush_sb_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a transfer
    @(posedge i_clk);
    #2;
    bus_mode = 0;
    i_mem_load_ff = 1'b1;
    i_mem_address_ff = 32'h0000_0500;
    @(posedge i_clk);
    #3;
    check("rstmid_busy", {31'd0, o_wb_stb}, 32'd1);
    i_reset = 1'b0;
    #1;
    check("rstmid_bus", {29'd0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
    check("rstmid_adr", o_wb_adr, 32'd0);
    check("rstmid_sel", {28'd0, o_wb_sel}, 32'd0);
    check("rstmid_flags", {29'd0, o_data_stall, o_mem_done, o_mem_fault}, 32'd0);
    check("rstmid_rd", o_mem_rd_data, 32'd0);
    check("rstmid_state", {30'd0, o_dbg_state}, 32'd0);
    model_rd = 32'd0;
    drop_req();
    @(posedge i_clk);
    #2;
    i_reset = 1'b1;
    @(posedge i_clk);
    #2;

    // Recovery after reset
    bus_mode = 1; bus_wait = 0; i_wb_dat = 32'h55AA_55AA;
    run_req("ld_recover", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0,
            32'h0000_0010, 4'b1111, 32'h0000_0000, 1'b0, 2, 1, 1'b0, 32'h55AA_55AA);
    model_rd = 32'h55AA_55AA;

    check("final_sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zap_dmem_request.md
Name: zap_dmem_request

Overview:
- Data-side bus initiator between the ALU stage and the memory stage.
- Accepts one load/store request per instruction from the ALU-stage flops. Formats store data (byte/halfword lane replication) and byte selects, then runs a Wishbone-style single transfer.
- Holds the pipeline with o_data_stall until the transfer completes, then presents the raw 32-bit read word and fault status. Load alignment and sign extension happen downstream.

Parameters:
- TIMEOUT, 255: bus watchdog limit in cycles from strobe assertion; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_clear_from_writeback  in  1  pipeline flush
- i_mem_load_ff  in  1  load request
- i_mem_store_ff  in  1  store request
- i_mem_address_ff  in  32  byte address
- i_mem_srcdest_value_ff  in  32  store data (right-justified)
- i_byte_ff  in  1  byte access
- i_half_ff  in  1  halfword access (word if neither)
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  bus strobe
- o_wb_we  out  1  write enable
- o_wb_adr  out  32  word-aligned address
- o_wb_dat  out  32  write data
- o_wb_sel  out  4  byte selects
- i_wb_dat  in  32  read data
- i_wb_ack  in  1  transfer acknowledge
- i_wb_err  in  1  bus error
- o_data_stall  out  1  pipeline stall
- o_mem_done  out  1  one-cycle completion pulse
- o_mem_rd_data  out  32  captured read word
- o_mem_fault  out  1  fault, valid with o_mem_done

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State IDLE.
  - All outputs 0.
  - Watchdog counter 0; flush flag 0.
- Request: req = i_mem_load_ff | i_mem_store_ff. If both are high, it is treated as a store.
- States: IDLE, BUSY, DONE.
- IDLE, on req & !i_clear_from_writeback, register the following and go to BUSY:
  - o_wb_cyc = o_wb_stb = 1.
  - o_wb_we = store.
  - o_wb_adr = {addr[31:2], 2'b00}.
  - Store byte: o_wb_sel = 4'b0001 << addr[1:0]; o_wb_dat = {4{d[7:0]}}.
  - Store half: o_wb_sel = addr[1] ? 4'b1100 : 4'b0011; o_wb_dat = {2{d[15:0]}}.
  - Store word: o_wb_sel = 4'b1111; o_wb_dat = d.
  - Load: o_wb_sel = 4'b1111; o_wb_dat = 0.
- IDLE with i_clear_from_writeback high: no request is accepted.
- BUSY:
  - Count cycles while waiting.
  - On i_wb_ack or i_wb_err: drop cyc/stb; capture i_wb_dat into o_mem_rd_data (loads only); register fault = i_wb_err; go to DONE.
  - On count reaching TIMEOUT (TIMEOUT≠0) with no ack: drop cyc/stb; fault = 1; go to DONE.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE:
  - o_mem_done = 1 and o_mem_fault = registered fault, for exactly one cycle; both suppressed if the flush flag is set.
  - Request inputs are ignored (same instruction still present).
  - Clear the flush flag; return to IDLE.
- o_data_stall (combinational) = (IDLE & req & !i_clear_from_writeback) | BUSY. It is low in DONE so the pipeline advances on that edge.
- Latency, zero-wait bus (request seen in cycle N):
  - Strobe in N+1.
  - Ack in N+1.
  - DONE in N+2; stall high in N and N+1.
  - IDLE in N+3.
- Flush during BUSY: the bus cycle runs to ack/err/timeout (never abandoned mid-transfer); the flush flag is set and the result is discarded.
- Reset mid-transfer: cyc/stb drop immediately (asynchronous).
- Watchdog counter is sized $clog2(TIMEOUT+1) and clears on entry to BUSY.

Optional Feature:
- Macro ZAP_DMEM_ALIGN_CHECK_EN.
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]≠0 goes IDLE→DONE with fault=1 and no bus cycle. Stall is high for one cycle.
- Undefined: misaligned low address bits are ignored, and lanes/selects are formed from addr[1:0] as above.

Test Plan:
- Store byte addr 0x103, data 0x000000A5, ack next cycle -> adr 0x100, sel 4'b1000, dat 0xA5A5A5A5, we=1; stall high 2 cycles; o_mem_done in N+2, fault 0.
- Load word addr 0x200, ack after 3 wait cycles, i_wb_dat 0xDEADBEEF -> sel 4'b1111, we=0; stall high 5 cycles; o_mem_rd_data 0xDEADBEEF with o_mem_done.
- Store half addr 0x2, data 0x1234 -> sel 4'b1100, dat 0x12341234; i_wb_err instead of ack -> o_mem_fault=1 with o_mem_done.
- TIMEOUT=4, no ack -> cyc/stb drop after 4 strobe cycles; fault pulse; IDLE; next request accepted normally.
- Flush asserted during BUSY -> stb held until ack; no o_mem_done/o_mem_fault pulse; i_reset=0 mid-BUSY -> all outputs 0 immediately.
- With ZAP_DMEM_ALIGN_CHECK_EN, word load addr 0x6 -> no cyc/stb; fault pulse in N+1; without the macro -> adr 0x4, sel 4'b1111.
